ucomb_cfg_seq: RTL and testbench



---
 rtl/ucomb_cfg_seq.sv | 131 +++++++++++++
 tb/tb_ucomb_cfg_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucomb_cfg_seq.sv
// ucomb_cfg_seq
// Sequencer that turns one (sel, func) configuration request into a packed
// wiring map for a universal gate. The sequencer walks pins 0..N-1 through an
// external ucomb wiring-lookup instance, one pin per cycle. Each one-hot wpin
// result becomes a 3-bit slot code. The finished map and an error flag are
// returned over a valid/ready handshake.
//
// Optional build macro: UCOMB_SEQ_ABORT_EN
//   Defined   - the scan stops at the first invalid wpin and the response is
//               produced immediately.
//   Undefined - all N pins are always scanned, so latency is fixed at N.
module ucomb_cfg_seq #(
  parameter int         SLOTS    = 10,
  parameter logic [2:0] BAD_CODE = 3'b111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic [15:0]        req_func,
  output logic [1:0]         comb_sel,
  output logic [15:0]        comb_func,
  output logic [3:0]         comb_pin,
  input  logic [5:0]         comb_wpin,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [3*SLOTS-1:0] resp_cfg,
  output logic               resp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sel;
  logic [15:0]        r_func;
  logic [3:0]         r_pin;
  logic [3*SLOTS-1:0] r_cfg;
  logic               r_err;

  logic [3:0]         w_last;
  logic               w_valid;
  logic [2:0]         w_code;

  // Last pin index (N-1) for the latched gate type
  always_comb begin
    // NOTE: give every always_comb output a default before any branch, so that no path can leave it unassigned and infer a latch.
    w_last = 4'd3;
    case (r_sel)
      2'b00:   w_last = 4'd3;  // u21: 4 pins
      2'b01:   w_last = 4'd5;  // u31: 6 pins
      2'b10:   w_last = 4'd9;  // u41: 10 pins
      default: w_last = 4'd5;  // u22: 6 pins
    endcase
  end

  // Encode the lookup result; a zero or multi-bit wpin maps to BAD_CODE
  always_comb begin
    w_code  = BAD_CODE;
    w_valid = (comb_wpin != 6'd0) && ((comb_wpin & (comb_wpin - 6'd1)) == 6'd0);
    if (w_valid) begin
      for (int j = 0; j < 6; j++) begin
        if (comb_wpin[j]) w_code = 3'(j);
      end
    end
  end

  // Sequencer: accept a request, scan the pins, then hold the map until it is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is written with non-blocking assignments, so every register samples its pre-edge values.
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_func  <= 16'd0;
      r_pin   <= 4'd0;
      r_cfg   <= {SLOTS{BAD_CODE}};
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_sel   <= req_sel;
            r_func  <= req_func;
            r_pin   <= 4'd0;
            r_cfg   <= {SLOTS{BAD_CODE}};
            r_err   <= 1'b0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_cfg[3*r_pin +: 3] <= w_code;
          if (!w_valid) r_err <= 1'b1;
`ifdef UCOMB_SEQ_ABORT_EN
          if (!w_valid || (r_pin == w_last)) begin
            r_state <= DONE;
          end else begin
            r_pin <= r_pin + 4'd1;
          end
`else
          if (r_pin == w_last) begin
            r_state <= DONE;
          end else begin
            r_pin <= r_pin + 4'd1;
          end
`endif
        end
        DONE: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake flags are decoded from registered state only
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign busy       = (r_state != IDLE);

  assign comb_sel   = r_sel;
  assign comb_func  = r_func;
  assign comb_pin   = r_pin;
  assign resp_cfg   = r_cfg;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_ucomb_cfg_seq.sv
// tb_ucomb_cfg_seq
// Randomised bench for ucomb_cfg_seq. A table-driven stub stands in for the
// ucomb wiring lookup: comb_wpin = wpin_tab[comb_pin]. The reference model
// derives the expected map, error flag and latency from that table using the
// encoding rules.
// Build with +define+UCOMB_SEQ_ABORT_EN to check the abort variant.
module tb_ucomb_cfg_seq;

  localparam int SLOTS = 10;
  localparam logic [3*SLOTS-1:0] ALL_BAD = '1;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_sel;
  logic [15:0]         req_func;
  logic [1:0]          comb_sel;
  logic [15:0]         comb_func;
  logic [3:0]          comb_pin;
  logic [5:0]          comb_wpin;
  logic                resp_valid;
  logic                resp_ready;
  logic [3*SLOTS-1:0]  resp_cfg;
  logic                resp_err;
  logic                busy;

  logic [5:0] wpin_tab [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Lookup stub
  assign comb_wpin = wpin_tab[comb_pin];

  ucomb_cfg_seq #(.SLOTS(SLOTS), .BAD_CODE(3'b111)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_func   (req_func),
    .comb_sel   (comb_sel),
    .comb_func  (comb_func),
    .comb_pin   (comb_pin),
    .comb_wpin  (comb_wpin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_cfg   (resp_cfg),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pins_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 4;
      2'b01:   return 6;
      2'b10:   return 10;
      default: return 6;
    endcase
  endfunction

  // Fill the lookup table with a random valid one-hot wiring for each pin
  task automatic fill_valid();
    for (int i = 0; i < 16; i++) wpin_tab[i] = 6'(1) << $urandom_range(0, 5);
  endtask

  // Fill the lookup table with a mix: roughly one pin in four is invalid (zero or multi-hot)
  task automatic fill_mixed();
    logic [5:0] v;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 6'($urandom_range(0, 63));
        if ($countones(v) == 1) v = 6'd0;
        wpin_tab[i] = v;
      end else begin
        wpin_tab[i] = 6'(1) << $urandom_range(0, 5);
      end
    end
  endtask

  // Reference model: expected map, error flag and accept-to-valid latency
  function automatic void model(input logic [1:0] sel, output logic [3*SLOTS-1:0] cfg,
                                output logic err, output int lat);
    int n;
    n   = pins_of(sel);
    cfg = ALL_BAD;
    err = 1'b0;
    lat = n;
    for (int k = 0; k < n; k++) begin
      if ($countones(wpin_tab[k]) == 1) begin
        for (int j = 0; j < 6; j++) if (wpin_tab[k][j]) cfg[3*k +: 3] = 3'(j);
      end else begin
        err = 1'b1;
`ifdef UCOMB_SEQ_ABORT_EN
        lat = k + 1;
        break;
`endif
      end
    end
  endfunction

  // Wait (bounded) for IDLE, then present one request for a single cycle
  task automatic accept(input string nm, input logic [1:0] sel, input logic [15:0] func);
    int cyc;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: req_ready=%b required 1", nm, req_ready);
    end
    req_valid = 1'b1;
    req_sel   = sel;
    req_func  = func;
    step();
  endtask

  // Follow the scan after an accept, check the response, hold it, and hand it off
  task automatic scan_finish(input string nm, input logic [1:0] sel, input logic [15:0] func,
                             input int hold, input bit junk, input bit b2b,
                             input logic [1:0] nsel, input logic [15:0] nfunc);
    logic [3*SLOTS-1:0] e_cfg;
    logic               e_err;
    int                 e_lat;
    int                 cyc;
    model(sel, e_cfg, e_err, e_lat);
    // Requests that arrive mid-scan must be ignored
    req_valid = junk;
    req_sel   = ~sel;
    req_func  = ~func;
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 20) begin
      checks++;
      if (comb_pin !== 4'(cyc) || comb_sel !== sel || comb_func !== func ||
          busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s scan_c%0d: pin=%0d sel=%b func=%h busy=%b rdy=%b required pin=%0d sel=%b func=%h busy=1 rdy=0",
                 nm, cyc, comb_pin, comb_sel, comb_func, busy, req_ready, cyc, sel, func);
      end
      step();
      cyc++;
    end
    req_valid = 1'b0;
    checks++;
    if (cyc !== e_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", nm, cyc, e_lat);
    end
    checks++;
    if (resp_cfg !== e_cfg) begin
      errors++;
      $display("FAIL %s resp_cfg: got %h required %h", nm, resp_cfg, e_cfg);
    end
    checks++;
    if (resp_err !== e_err) begin
      errors++;
      $display("FAIL %s resp_err: got %b required %b", nm, resp_err, e_err);
    end
    checks++;
    if (comb_pin !== 4'(e_lat - 1) || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s done_state: pin=%0d rdy=%b busy=%b required pin=%0d rdy=0 busy=1",
               nm, comb_pin, req_ready, busy, e_lat - 1);
    end
    for (int h = 0; h < hold; h++) begin
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_cfg !== e_cfg || resp_err !== e_err || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold_c%0d: valid=%b cfg=%h err=%b rdy=%b required valid=1 cfg=%h err=%b rdy=0",
                 nm, h, resp_valid, resp_cfg, resp_err, req_ready, e_cfg, e_err);
      end
    end
    resp_ready = 1'b1;
    if (b2b) begin
      req_valid = 1'b1;
      req_sel   = nsel;
      req_func  = nfunc;
    end
    step();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 ||
        resp_cfg !== e_cfg || resp_err !== e_err) begin
      errors++;
      $display("FAIL %s handoff: valid=%b rdy=%b busy=%b cfg=%h err=%b required valid=0 rdy=1 busy=0 cfg=%h err=%b",
               nm, resp_valid, req_ready, busy, resp_cfg, resp_err, e_cfg, e_err);
    end
    if (b2b) begin
      step();
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || comb_sel !== nsel || comb_func !== nfunc || comb_pin !== 4'd0) begin
        errors++;
        $display("FAIL %s b2b_accept: busy=%b sel=%b func=%h pin=%0d required busy=1 sel=%b func=%h pin=0",
                 nm, busy, comb_sel, comb_func, comb_pin, nsel, nfunc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: rdy=%b valid=%b err=%b busy=%b required 1 0 0 0",
               req_ready, resp_valid, resp_err, busy);
    end
    checks++;
    if (comb_sel !== 2'd0 || comb_func !== 16'd0 || comb_pin !== 4'd0) begin
      errors++;
      $display("FAIL reset_comb: sel=%b func=%h pin=%0d required 0 0 0", comb_sel, comb_func, comb_pin);
    end
    checks++;
    if (resp_cfg !== ALL_BAD) begin
      errors++;
      $display("FAIL reset_cfg: got %h required %h", resp_cfg, ALL_BAD);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_u41_valid();
    logic [15:0] f;
    for (int r = 0; r < 3; r++) begin
      fill_valid();
      f = 16'($urandom);
      accept("u41_valid", 2'b10, f);
      scan_finish("u41_valid", 2'b10, f, 0, 1'b0, 1'b0, 2'b00, 16'h0);
    end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 16; i++) wpin_tab[i] = 6'd0;
    accept("u21_zero", 2'b00, 16'h0010);
    scan_finish("u21_zero", 2'b00, 16'h0010, 0, 1'b0, 1'b0, 2'b00, 16'h0);
    checks++;
    if (resp_cfg !== 30'h3FFFFFFF || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL u21_zero_const: cfg=%h err=%b required 3fffffff 1", resp_cfg, resp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f1;
    logic [15:0] f2;
    fill_valid();
    f1 = 16'($urandom);
    f2 = 16'($urandom);
    accept("u31_hold", 2'b01, f1);
    scan_finish("u31_hold", 2'b01, f1, 5, 1'b1, 1'b1, 2'b11, f2);
    scan_finish("u22_after_b2b", 2'b11, f2, 0, 1'b0, 1'b0, 2'b00, 16'h0);
  endtask

  task automatic test_u22();
    logic [15:0] f;
    fill_valid();
    f = 16'($urandom);
    accept("u22", 2'b11, f);
    scan_finish("u22", 2'b11, f, 1, 1'b1, 1'b0, 2'b00, 16'h0);
  endtask

  task automatic test_mid_reset();
    int cyc;
    fill_valid();
    accept("mid_rst", 2'b10, 16'hBEEF);
    cyc = 0;
    while (comb_pin !== 4'd3 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (comb_pin !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_reach: pin=%0d busy=%b required pin=3 busy=1", comb_pin, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || resp_err !== 1'b0 ||
        comb_pin !== 4'd0 || resp_cfg !== ALL_BAD) begin
      errors++;
      $display("FAIL mid_rst_state: rdy=%b valid=%b busy=%b err=%b pin=%0d cfg=%h required 1 0 0 0 0 %h",
               req_ready, resp_valid, busy, resp_err, comb_pin, resp_cfg, ALL_BAD);
    end
    fill_valid();
    accept("after_rst", 2'b00, 16'h1234);
    scan_finish("after_rst", 2'b00, 16'h1234, 0, 1'b0, 1'b0, 2'b00, 16'h0);
  endtask

  task automatic test_forced_multi();
    fill_valid();
    wpin_tab[2] = 6'b000011;
    accept("multi_pin2", 2'b10, 16'h5A5A);
    scan_finish("multi_pin2", 2'b10, 16'h5A5A, 0, 1'b0, 1'b0, 2'b00, 16'h0);
    checks++;
    if (resp_cfg[8:6] !== 3'b111 || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_pin2_slot: slot2=%b err=%b required 111 1", resp_cfg[8:6], resp_err);
    end
  endtask

  task automatic test_random_mix();
    logic [1:0]  s;
    logic [15:0] f;
    for (int r = 0; r < 8; r++) begin
      fill_mixed();
      s = 2'($urandom_range(0, 3));
      f = 16'($urandom);
      accept("random_mix", s, f);
      scan_finish("random_mix", s, f, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'b0, 2'b00, 16'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wpin_tab[i] = 6'd1;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_sel    = 2'b00;
    req_func   = 16'h0;
    resp_ready = 1'b0;
    #1;
    test_reset();
    test_u41_valid();
    test_all_zero();
    test_back_to_back();
    test_u22();
    test_mid_reset();
    test_forced_multi();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
